// File: rtl/timer_ctrl_fsm_pkg.sv
// Shared types and constants for the countdown-timer front-panel sequencer.
// States, edit-field select codes and BCD field limits.
package timer_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StEditH,
        StEditM,
        StEditS,
        StLoad,
        StArm,
        StRun,
        StPause,
        StAlarm
    } state_e;

    localparam logic [1:0] SelNone   = 2'd0;
    localparam logic [1:0] SelHour   = 2'd1;
    localparam logic [1:0] SelMinute = 2'd2;
    localparam logic [1:0] SelSecond = 2'd3;

    localparam logic [7:0] BcdMaxMinSec = 8'h59;
    localparam logic [7:0] BcdMaxHour   = 8'h23;

endpackage

// File: rtl/timer_ctrl_fsm_if.sv
// Front-panel bus: debounced buttons and timer flags in, presets, strobes and buzzer out.
// The slave modport is the sequencer side; master is the panel/timer side.
interface timer_ctrl_fsm_if;

    logic       btn_mode;
    logic       btn_up;
    logic       btn_start;
    logic       counting;
    logic       ring;
    logic [7:0] hour_bcd;
    logic [7:0] minute_bcd;
    logic [7:0] second_bcd;
    logic       set;
    logic       play;
    logic       stop;
    logic [1:0] edit_sel;
    logic       ring_out;

    modport master (
        output btn_mode, btn_up, btn_start, counting, ring,
        input  hour_bcd, minute_bcd, second_bcd, set, play, stop, edit_sel, ring_out
    );

    modport slave (
        input  btn_mode, btn_up, btn_start, counting, ring,
        output hour_bcd, minute_bcd, second_bcd, set, play, stop, edit_sel, ring_out
    );

endinterface

// File: rtl/timer_ctrl_fsm_bcd_field_inc.sv
// Two-digit BCD increment that wraps to 00 once the value reaches max_i.
module bcd_field_inc (
    input  logic [7:0] value_i,
    input  logic [7:0] max_i,
    output logic [7:0] value_o
);

    always_comb begin
        value_o = value_i;
        if (value_i >= max_i) begin
            value_o = 8'h00;
        end else if (value_i[3:0] == 4'd9) begin
            value_o = {value_i[7:4] + 4'd1, 4'd0};
        end else begin
            value_o = {value_i[7:4], value_i[3:0] + 4'd1};
        end
    end

endmodule

// File: rtl/timer_ctrl_fsm.sv
// Front-panel sequencer: edits BCD presets and drives set/play/stop strobes and the buzzer.
// Optional TIMER_AUTO_RELOAD_EN: ring in RUN reloads and restarts while the alarm sounds.
module timer_ctrl_fsm
    import timer_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 50000000,
    parameter int unsigned SET_HOLD  = 60000,
    parameter int unsigned ALARM_SEC = 10,
    parameter logic [7:0]  HOUR_MAX  = BcdMaxHour
) (
    input logic              clk,
    input logic              rst_n,
    timer_ctrl_fsm_if.slave  bus
);

    state_e      state_q, state_d;
    logic [7:0]  hour_q, hour_d, minute_q, minute_d, second_q, second_d;
    logic [31:0] hold_q, hold_d;
    logic [2:0]  lost_q, lost_d;
    logic [31:0] alm_cyc_q, alm_cyc_d, alm_sec_q, alm_sec_d;
    logic        ring_q, ring_out_q, ring_out_d;
    logic        play_q, play_d, stop_q, stop_d;

    logic [1:0]  edit_sel;
    logic [7:0]  sel_val, sel_max, inc_val;
    logic        ring_rise, presets_zero, alarm_done, ack, start_ev;

    assign ring_rise    = bus.ring & ~ring_q;
    assign presets_zero = (hour_q == 8'h00) && (minute_q == 8'h00) && (second_q == 8'h00);
    assign alarm_done   = ring_out_q && (alm_cyc_q == CLK_HZ - 1) && (alm_sec_q == ALARM_SEC - 1);

`ifdef TIMER_AUTO_RELOAD_EN
    // While the buzzer sounds, start only acknowledges it and never reaches the FSM.
    assign ack = bus.btn_start & ring_out_q;
`else
    assign ack = 1'b0;
`endif
    assign start_ev = bus.btn_start & ~ack;

    always_comb begin
        unique case (state_q)
            StEditH: edit_sel = SelHour;
            StEditM: edit_sel = SelMinute;
            StEditS: edit_sel = SelSecond;
            default: edit_sel = SelNone;
        endcase
    end

    always_comb begin
        sel_val = second_q;
        sel_max = BcdMaxMinSec;
        case (edit_sel)
            SelHour: begin
                sel_val = hour_q;
                sel_max = HOUR_MAX;
            end
            SelMinute: sel_val = minute_q;
            default: ;
        endcase
    end

    bcd_field_inc u_inc (
        .value_i (sel_val),
        .max_i   (sel_max),
        .value_o (inc_val)
    );

    always_comb begin
        state_d    = state_q;
        hour_d     = hour_q;
        minute_d   = minute_q;
        second_d   = second_q;
        hold_d     = '0;
        lost_d     = '0;
        play_d     = 1'b0;
        stop_d     = 1'b0;
        ring_out_d = ring_out_q;
        alm_cyc_d  = '0;
        alm_sec_d  = '0;

        if (ring_out_q) begin
            if (alm_cyc_q == CLK_HZ - 1) begin
                alm_sec_d = alm_sec_q + 32'd1;
                if (alarm_done) ring_out_d = 1'b0;
            end else begin
                alm_cyc_d = alm_cyc_q + 32'd1;
                alm_sec_d = alm_sec_q;
            end
        end
        if (ack) ring_out_d = 1'b0;

        case (state_q)
            StIdle: begin
                if (start_ev) begin
                    if (!presets_zero) state_d = StLoad;
                end else if (bus.btn_mode) begin
                    state_d = StEditH;
                end
            end
            StEditH, StEditM, StEditS: begin
                if (start_ev) begin
                    if (!presets_zero) state_d = StLoad;
                end else if (bus.btn_mode) begin
                    state_d = (state_q == StEditH) ? StEditM :
                              (state_q == StEditM) ? StEditS : StIdle;
                end else if (bus.btn_up) begin
                    case (edit_sel)
                        SelHour:   hour_d   = inc_val;
                        SelMinute: minute_d = inc_val;
                        default:   second_d = inc_val;
                    endcase
                end
            end
            StLoad: begin
                if (hold_q == SET_HOLD - 1) state_d = StArm;
                else hold_d = hold_q + 32'd1;
            end
            StArm: state_d = StRun;
            StRun: begin
                if (start_ev) begin
                    stop_d  = 1'b1;
                    state_d = StPause;
                end else if (bus.btn_mode) begin
                    stop_d  = 1'b1;
                    state_d = StIdle;
                end else if (ring_rise) begin
                    ring_out_d = 1'b1;
`ifdef TIMER_AUTO_RELOAD_EN
                    state_d    = StLoad;
                    alm_cyc_d  = '0;
                    alm_sec_d  = '0;
`else
                    state_d    = StAlarm;
`endif
                end else if (!bus.counting && !bus.ring) begin
                    // Timer never picked up the play strobe: give up after 4 quiet cycles.
                    if (lost_q == 3'd3) state_d = StIdle;
                    else lost_d = lost_q + 3'd1;
                end
            end
            StPause: begin
                if (start_ev) begin
                    play_d  = 1'b1;
                    state_d = StRun;
                end else if (bus.btn_mode) begin
                    state_d = StIdle;
                end
            end
            StAlarm: begin
                if (start_ev || alarm_done) begin
                    ring_out_d = 1'b0;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            hour_q     <= 8'h00;
            minute_q   <= 8'h00;
            second_q   <= 8'h00;
            hold_q     <= '0;
            lost_q     <= '0;
            alm_cyc_q  <= '0;
            alm_sec_q  <= '0;
            ring_q     <= 1'b0;
            ring_out_q <= 1'b0;
            play_q     <= 1'b0;
            stop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hour_q     <= hour_d;
            minute_q   <= minute_d;
            second_q   <= second_d;
            hold_q     <= hold_d;
            lost_q     <= lost_d;
            alm_cyc_q  <= alm_cyc_d;
            alm_sec_q  <= alm_sec_d;
            ring_q     <= bus.ring;
            ring_out_q <= ring_out_d;
            play_q     <= play_d;
            stop_q     <= stop_d;
        end
    end

    assign bus.hour_bcd   = hour_q;
    assign bus.minute_bcd = minute_q;
    assign bus.second_bcd = second_q;
    assign bus.set        = (state_q == StLoad);
    assign bus.play       = (state_q == StArm) | play_q;
    assign bus.stop       = stop_q;
    assign bus.edit_sel   = edit_sel;
    assign bus.ring_out   = ring_out_q;

endmodule

// File: tb/tb_timer_ctrl_fsm.sv
// Directed bench for timer_ctrl_fsm: vector table for editing, hand sequences for
// load/run/pause/alarm/reset corners. Small CLK_HZ and SET_HOLD keep the run short.
module tb_timer_ctrl_fsm;

    localparam int unsigned CLK_HZ    = 1000;
    localparam int unsigned SET_HOLD  = 2000;
    localparam int unsigned ALARM_SEC = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    timer_ctrl_fsm_if bus ();

    timer_ctrl_fsm #(
        .CLK_HZ    (CLK_HZ),
        .SET_HOLD  (SET_HOLD),
        .ALARM_SEC (ALARM_SEC),
        .HOUR_MAX  (8'h23)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       m, u, s;
        logic [7:0] h, mi, se;
        logic [1:0] sel;
        logic       setv;
    } vec_t;

    vec_t vecs[14];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic press(input logic m, input logic u, input logic s);
        bus.btn_mode  = m;
        bus.btn_up    = u;
        bus.btn_start = s;
        tick();
        bus.btn_mode  = 1'b0;
        bus.btn_up    = 1'b0;
        bus.btn_start = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.btn_mode = 1'b0;
        bus.btn_up = 1'b0;
        bus.btn_start = 1'b0;
        bus.ring = 1'b0;
        bus.counting = 1'b1;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Starts from IDLE with nonzero presets; returns when play (ARM) is visible.
    task automatic start_and_wait_play();
        int n;
        press(1'b0, 1'b0, 1'b1);
        n = 0;
        while (bus.play !== 1'b1 && n < SET_HOLD + 50) begin
            tick();
            n++;
        end
        check("wait_play_timeout", {31'd0, bus.play}, 32'd1);
    endtask

    initial begin
        int n;
        // {mode, up, start} -> {hour, minute, second, edit_sel, set}
        vecs[0]  = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 2'd0, 1'b0}; // zero guard
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 2'd0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 2'd1, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 8'h01, 8'h00, 8'h00, 2'd1, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 8'h02, 8'h00, 8'h00, 2'd1, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 8'h02, 8'h00, 8'h00, 2'd2, 1'b0}; // mode beats up
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 8'h02, 8'h01, 8'h00, 2'd2, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 8'h02, 8'h01, 8'h00, 2'd3, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 8'h02, 8'h01, 8'h01, 2'd3, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 8'h02, 8'h01, 8'h02, 2'd3, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 8'h02, 8'h01, 8'h02, 2'd0, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 8'h02, 8'h01, 8'h02, 2'd0, 1'b0}; // up ignored in IDLE
        vecs[12] = '{1'b1, 1'b0, 1'b1, 8'h02, 8'h01, 8'h02, 2'd0, 1'b1}; // start beats mode
        vecs[13] = '{1'b1, 1'b1, 1'b0, 8'h02, 8'h01, 8'h02, 2'd0, 1'b1}; // LOAD ignores buttons

        do_reset();
        check("rst_hour", {24'd0, bus.hour_bcd}, 32'h00);
        check("rst_min", {24'd0, bus.minute_bcd}, 32'h00);
        check("rst_sec", {24'd0, bus.second_bcd}, 32'h00);
        check("rst_strobes", {28'd0, bus.set, bus.play, bus.stop, bus.ring_out}, 32'd0);
        check("rst_sel", {30'd0, bus.edit_sel}, 32'd0);

        for (int i = 0; i < 14; i++) begin
            press(vecs[i].m, vecs[i].u, vecs[i].s);
            check($sformatf("vec%0d_hour", i), {24'd0, bus.hour_bcd}, {24'd0, vecs[i].h});
            check($sformatf("vec%0d_min", i), {24'd0, bus.minute_bcd}, {24'd0, vecs[i].mi});
            check($sformatf("vec%0d_sec", i), {24'd0, bus.second_bcd}, {24'd0, vecs[i].se});
            check($sformatf("vec%0d_sel", i), {30'd0, bus.edit_sel}, {30'd0, vecs[i].sel});
            check($sformatf("vec%0d_set", i), {31'd0, bus.set}, {31'd0, vecs[i].setv});
            check($sformatf("vec%0d_play", i), {31'd0, bus.play}, 32'd0);
        end

        // Field wrap: hour 23 -> 00, minute 59 -> 00.
        do_reset();
        press(1'b1, 1'b0, 1'b0);
        repeat (23) press(1'b0, 1'b1, 1'b0);
        check("hour_max", {24'd0, bus.hour_bcd}, 32'h23);
        press(1'b0, 1'b1, 1'b0);
        check("hour_wrap", {24'd0, bus.hour_bcd}, 32'h00);
        press(1'b1, 1'b0, 1'b0);
        repeat (59) press(1'b0, 1'b1, 1'b0);
        check("min_max", {24'd0, bus.minute_bcd}, 32'h59);
        press(1'b0, 1'b1, 1'b0);
        check("min_wrap", {24'd0, bus.minute_bcd}, 32'h00);

        // Preset 00:00:05 and load.
        do_reset();
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        repeat (5) press(1'b0, 1'b1, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        check("preset_sec", {24'd0, bus.second_bcd}, 32'h05);
        press(1'b0, 1'b0, 1'b1);
        n = 0;
        while (bus.set === 1'b1 && n < SET_HOLD + 20) begin
            if (bus.play !== 1'b0 || bus.stop !== 1'b0) begin
                check("load_excl", {30'd0, bus.play, bus.stop}, 32'd0);
            end
            n++;
            tick();
        end
        check("set_hold_len", n, SET_HOLD);
        check("arm_play", {30'd0, bus.play, bus.set}, 32'd2);
        tick();
        check("arm_play_one", {31'd0, bus.play}, 32'd0);

        // RUN -> PAUSE -> RUN.
        press(1'b0, 1'b0, 1'b1);
        check("pause_stop", {29'd0, bus.set, bus.play, bus.stop}, 32'd1);
        tick();
        check("pause_stop_one", {31'd0, bus.stop}, 32'd0);
        press(1'b0, 1'b0, 1'b1);
        check("resume_play", {29'd0, bus.set, bus.play, bus.stop}, 32'd2);
        tick();
        check("resume_play_one", {31'd0, bus.play}, 32'd0);

        // Ring edge -> ALARM, full timeout.
        bus.ring = 1'b1;
        tick();
        n = 0;
        while (bus.ring_out === 1'b1 && n < 2 * ALARM_SEC * CLK_HZ) begin
            n++;
            tick();
        end
        check("alarm_len", n, ALARM_SEC * CLK_HZ);
        press(1'b1, 1'b0, 1'b0); // ring still high: must be IDLE, not re-alarmed
        check("alarm_to_idle", {29'd0, bus.edit_sel, bus.ring_out}, 32'd2);
        repeat (3) press(1'b1, 1'b0, 1'b0);

        // Held ring must not retrigger; then early acknowledge at cycle 100.
        start_and_wait_play();
        repeat (6) tick();
        check("ring_held_no_retrig", {31'd0, bus.ring_out}, 32'd0);
        bus.ring = 1'b0;
        tick();
        bus.ring = 1'b1;
        tick();
        check("alarm_on", {31'd0, bus.ring_out}, 32'd1);
        repeat (99) tick();
        check("alarm_still_on", {31'd0, bus.ring_out}, 32'd1);
        press(1'b0, 1'b0, 1'b1);
        check("alarm_ack", {31'd0, bus.ring_out}, 32'd0);
        check("presets_kept", {8'd0, bus.hour_bcd, bus.minute_bcd, bus.second_bcd}, 32'h000005);
        bus.ring = 1'b0;

        // PAUSE with start+mode together resumes; mode in RUN cancels with stop.
        start_and_wait_play();
        tick();
        press(1'b0, 1'b0, 1'b1);
        press(1'b1, 1'b0, 1'b1);
        check("pause_prio_play", {30'd0, bus.play, bus.stop}, 32'd2);
        press(1'b1, 1'b0, 1'b0);
        check("cancel_stop", {29'd0, bus.set, bus.play, bus.stop}, 32'd1);
        press(1'b1, 1'b0, 1'b0);
        check("cancel_idle", {30'd0, bus.edit_sel}, 32'd1);
        repeat (3) press(1'b1, 1'b0, 1'b0);

        // Lost start: counting low 4 RUN cycles returns to IDLE without stop.
        start_and_wait_play();
        bus.counting = 1'b0;
        repeat (5) tick();
        press(1'b1, 1'b0, 1'b0);
        check("lost_no_stop", {31'd0, bus.stop}, 32'd0);
        check("lost_idle", {30'd0, bus.edit_sel}, 32'd1);
        bus.counting = 1'b1;
        repeat (3) press(1'b1, 1'b0, 1'b0);

        // Reset in the middle of LOAD.
        press(1'b0, 1'b0, 1'b1);
        check("load_set", {31'd0, bus.set}, 32'd1);
        repeat (10) tick();
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_strobes", {28'd0, bus.set, bus.play, bus.stop, bus.ring_out}, 32'd0);
        check("rst_mid_presets", {8'd0, bus.hour_bcd, bus.minute_bcd, bus.second_bcd}, 32'd0);
        check("rst_mid_sel", {30'd0, bus.edit_sel}, 32'd0);
        #3 rst_n = 1'b1;
        repeat (3) tick();
        check("post_rst_quiet", {29'd0, bus.set, bus.play, bus.stop}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/timer_ctrl_fsm.md
Name: timer_ctrl_fsm

Overview:
- Front-panel sequencer for the countdown timer: turns three debounced button pulses (mode, up, start) into edited BCD preset values and correctly timed set/play/stop strobes.
- Watches the timer's ring/counting flags and times out the alarm.
- Sits between the button debouncers and count_down_timer, on the 50 MHz system clock.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- SET_HOLD, 60000, cycles the set strobe is held; must exceed one 1 kHz period so the slow counter samples it.
- ALARM_SEC, 10, seconds ring_out stays high before auto-silence.
- HOUR_MAX, 8'h23, maximum editable hour (BCD).

Ports:
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous active-low reset
- btn_mode  in  1  single-cycle pulse, debounced; cycles edit field / cancels
- btn_up  in  1  single-cycle pulse; increments selected field
- btn_start  in  1  single-cycle pulse; start/pause/resume/acknowledge
- counting  in  1  timer counting flag
- ring  in  1  timer expiry flag
- hour_bcd  out  8  preset hours, BCD
- minute_bcd  out  8  preset minutes, BCD
- second_bcd  out  8  preset seconds, BCD
- set  out  1  load strobe to timer, held SET_HOLD cycles
- play  out  1  single-cycle start strobe
- stop  out  1  single-cycle stop strobe
- edit_sel  out  2  0 none, 1 hour, 2 minute, 3 second (display blink select)
- ring_out  out  1  buzzer enable

Behaviour:
- Clock and reset: one clock, clk. Asynchronous active-low reset, rst_n.
- Reset values:
  - State IDLE.
  - hour_bcd, minute_bcd, second_bcd = 8'h00.
  - set, play, stop, ring_out = 0.
  - edit_sel = 0.
  - All counters = 0.
- States: IDLE, EDIT_H, EDIT_M, EDIT_S, LOAD, ARM, RUN, PAUSE, ALARM.
- IDLE:
  - btn_mode -> EDIT_H.
  - btn_start -> LOAD, unless all three presets are 00; then remain in IDLE (zero guard).
- EDIT_H, EDIT_M, EDIT_S:
  - edit_sel = 1, 2, 3 respectively.
  - btn_up increments the field in BCD, taking effect on the next cycle.
  - Hour wraps HOUR_MAX -> 00. Minute and second wrap 59 -> 00.
  - btn_mode advances H -> M -> S -> IDLE.
  - btn_start -> LOAD, with the same zero guard.
- LOAD:
  - set = 1 for exactly SET_HOLD cycles; a hold counter counts to SET_HOLD-1, then -> ARM.
  - All buttons are ignored.
- ARM: play = 1 for exactly one cycle, then -> RUN.
- RUN:
  - btn_start -> stop pulse for 1 cycle, then -> PAUSE.
  - ring rising edge -> ALARM.
  - btn_mode -> stop pulse, then -> IDLE (cancel).
  - If counting is low for 4 consecutive cycles with ring low -> IDLE (lost-start recovery).
- PAUSE:
  - btn_start -> play pulse, then -> RUN.
  - btn_mode -> IDLE.
- ALARM:
  - ring_out = 1.
  - A seconds counter derived from CLK_HZ runs.
  - btn_start, or ALARM_SEC elapsed -> ring_out = 0, then -> IDLE.
  - Presets are retained for the next run.
- Simultaneous pulses: btn_start has priority over btn_mode, which has priority over btn_up. Losers are dropped, not queued.
- Strobe exclusivity: set, play and stop are mutually exclusive in every cycle.
- Reset mid-operation: everything returns to reset values immediately; no strobe is emitted.
- ring edge detection: a registered copy of ring is kept; ring held high does not retrigger ALARM.

Optional Feature:
- Macro: TIMER_AUTO_RELOAD_EN.
- Defined: on ring rising edge in RUN, raise ring_out, enter LOAD, then ARM, then RUN again using the same presets. The alarm timer runs concurrently and clears ring_out after ALARM_SEC; btn_start clears it early. btn_mode stops the timer (stop pulse) and returns to IDLE.
- Undefined: behaviour exactly as specified above.

Decomposition:
- Shared package timer_pkg holds:
  - State enum encoding.
  - edit_sel field codes.
  - BCD limit constants 8'h59 and 8'h23.
- Sub-module bcd_field_inc: combinational two-digit BCD increment with wrap at a max input. Instantiated once and muxed by edit_sel.

Test Plan:
- Reset, then btn_start with presets 00:00:00 -> remains IDLE; no set/play strobe.
- btn_mode; btn_up x24; btn_mode; btn_up x60 -> hour_bcd = 8'h00 (wrapped after 23), minute_bcd = 8'h00 (wrapped after 59).
- Preset 00:00:05, then btn_start -> set high for exactly 60000 cycles, play high for 1 cycle on the next cycle, state RUN.
- In RUN, btn_start -> stop 1-cycle pulse. btn_start again -> play 1-cycle pulse. set never asserted.
- Force ring rising edge in RUN -> ring_out = 1, cleared after ALARM_SEC × CLK_HZ cycles (use CLK_HZ=1000 in sim). Repeat with btn_start at cycle 100 -> ring_out cleared on the next cycle.
- btn_start and btn_mode in the same cycle in PAUSE -> resume (play pulse), not cancel. Assert rst_n low during LOAD -> set drops immediately, outputs return to reset values.
